alu_writeback: RTL and testbench

Two-entry result buffer and architectural flag register sitting directly downstream of the 8-bit combinational ALU. It captures the ALU result with its destination register address. It then presents the result to the register-file write port through a valid/ready handshake. It also updates the Zero/Parity/Odd flags that branch logic reads, and optionally forwards pending results to the operand-select stage.

---
 rtl/alu_writeback.sv | 124 ++++++++++++
 tb/tb_alu_writeback.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: two-entry result buffer plus Zero/Parity/Odd flag register behind the ALU.
// Latency: accepted result visible on o_wb_* one cycle later; flags update at the accepting edge.
// Backpressure: o_in_ready drops only when both entries are full (registered count), independent of i_wb_ready.
// Optional forwarding lookup is built when ALU_WB_FWD_EN is defined; otherwise o_fwd_hit/o_fwd_data are 0.
module alu_writeback #(
  parameter int W  = 8,
  parameter int RA = 3
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [W-1:0]  i_alu_out,
  input  logic [RA-1:0] i_dst_addr,
  input  logic          i_reg_we,
  input  logic          i_flag_we,
  input  logic          i_flush,
  output logic          o_wb_valid,
  input  logic          i_wb_ready,
  output logic [RA-1:0] o_wb_addr,
  output logic [W-1:0]  o_wb_data,
  output logic          o_zero_flag,
  output logic          o_parity_flag,
  output logic          o_odd_flag,
  input  logic [RA-1:0] i_query_addr,
  output logic          o_fwd_hit,
  output logic [W-1:0]  o_fwd_data
);

  logic [1:0]    r_count;
  logic          r_head;
  logic          r_tail;
  logic [RA-1:0] r_addr [2];
  logic [W-1:0]  r_data [2];

  logic w_accept;
  logic w_enq;
  logic w_deq;

  // Ready and writeback outputs come straight from state; only reset gates ready combinationally.
  assign o_in_ready = i_reset_n && (r_count != 2'd2);
  assign o_wb_valid = (r_count != 2'd0);
  assign o_wb_addr  = o_wb_valid ? r_addr[r_head] : '0;
  assign o_wb_data  = o_wb_valid ? r_data[r_head] : '0;

  // A flush cycle swallows the input entirely; RegWe=0 results are consumed but never stored.
  assign w_accept = i_in_valid && o_in_ready && !i_flush;
  assign w_enq    = w_accept && i_reg_we;
  assign w_deq    = o_wb_valid && i_wb_ready;

  // Pointer and occupancy tracking; flush empties the buffer after any same-cycle dequeue completes.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else if (i_flush) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_enq) r_tail <= ~r_tail;
      if (w_deq) r_head <= ~r_head;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage written at the tail slot on enqueue.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (w_enq) begin
      r_addr[r_tail] <= i_dst_addr;
      r_data[r_tail] <= i_alu_out;
    end
  end

  // Architectural flags load from any accepted FlagWe result, stored or not.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_zero_flag   <= 1'b0;
      o_parity_flag <= 1'b0;
      o_odd_flag    <= 1'b0;
    end else if (w_accept && i_flag_we) begin
      o_zero_flag   <= (i_alu_out == '0);
      o_parity_flag <= ^i_alu_out;
      o_odd_flag    <= i_alu_out[0];
    end
  end

`ifdef ALU_WB_FWD_EN
  logic w_newest;
  logic w_oldest;
  assign w_newest = ~r_tail;
  assign w_oldest = r_tail;

  // Lookup over stored entries; the newest slot is evaluated last so it wins on a double match.
  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    if ((r_count == 2'd2) && (r_addr[w_oldest] == i_query_addr)) begin
      o_fwd_hit  = 1'b1;
      o_fwd_data = r_data[w_oldest];
    end
    if ((r_count != 2'd0) && (r_addr[w_newest] == i_query_addr)) begin
      o_fwd_hit  = 1'b1;
      o_fwd_data = r_data[w_newest];
    end
  end
`else
  logic w_unused_query;
  assign w_unused_query = ^i_query_addr;
  assign o_fwd_hit      = 1'b0;
  assign o_fwd_data     = '0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: scoreboard queue of expected writebacks, one task per scenario.
module tb_alu_writeback;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu;
  logic [2:0] dst;
  logic       reg_we;
  logic       flag_we;
  logic       flush;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       zf;
  logic       pf;
  logic       of;
  logic [2:0] query;
  logic       fwd_hit;
  logic [7:0] fwd_data;

  wb_t q[$];
  wb_t exp_wb;
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  alu_writeback #(.W(8), .RA(3)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_alu_out    (alu),
    .i_dst_addr   (dst),
    .i_reg_we     (reg_we),
    .i_flag_we    (flag_we),
    .i_flush      (flush),
    .o_wb_valid   (wb_valid),
    .i_wb_ready   (wb_ready),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_data),
    .o_zero_flag  (zf),
    .o_parity_flag(pf),
    .o_odd_flag   (of),
    .i_query_addr (query),
    .o_fwd_hit    (fwd_hit),
    .o_fwd_data   (fwd_data)
  );

  // Scoreboard consumer: every completed writeback handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, expected no writeback", wb_addr, wb_data);
      end else begin
        exp_wb = q.pop_front();
        if ({wb_addr, wb_data} !== {exp_wb.addr, exp_wb.data}) begin
          bad++;
          $display("FAIL wb_entry: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wb_addr, wb_data, exp_wb.addr, exp_wb.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    reg_we   = 1'b0;
    flag_we  = 1'b0;
    flush    = 1'b0;
    alu      = 8'h00;
    dst      = 3'd0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d entries still pending, expected 0", name, q.size());
      q.delete();
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; reg_we = 1'b1; flag_we = 1'b1; flush = 1'b0;
    alu = 8'hFF; dst = 3'd1; wb_ready = 1'b1; query = 3'd1;
    step(); step();
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    total++; if ({wb_addr, wb_data} !== 11'd0) begin bad++; $display("FAIL reset_wb_bus: got %h/%h want 0/0", wb_addr, wb_data); end
    total++; if ({zf, pf, of} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {zf, pf, of}); end
    total++; if ({fwd_hit, fwd_data} !== 9'd0) begin bad++; $display("FAIL reset_fwd: got %b/%h want 0/00", fwd_hit, fwd_data); end
    step();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_single();
    in_valid = 1'b1; alu = 8'h2A; dst = 3'd5; reg_we = 1'b1; flag_we = 1'b1; wb_ready = 1'b1;
    q.push_back(wb_t'{3'd5, 8'h2A});
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid: got %b want 0", wb_valid); end
    step();
    idle_inputs();
    @(negedge clk);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", wb_valid); end
    total++; if ({zf, pf, of} !== 3'b010) begin bad++; $display("FAIL single_flags: got %b want 010", {zf, pf, of}); end
    step();
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_post_valid: got %b want 0", wb_valid); end
    step();
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0; in_valid = 1'b1; reg_we = 1'b1; flag_we = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      alu = 8'(i); dst = 3'(i);
      q.push_back(wb_t'{3'(i), 8'(i)});
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d: got %b want 1", i, in_ready); end
      step();
    end
    alu = 8'h03; dst = 3'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_%0d: got %b want 0", i, in_ready); end
      step();
    end
    wb_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_deq: got %b want 0", in_ready); end
    step();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reaccept: got %b want 1", in_ready); end
    q.push_back(wb_t'{3'd3, 8'h03});
    step();
    idle_inputs();
    wait_drain("bp");
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", wb_valid); end
    step();
  endtask

  task automatic test_cmp();
    wb_ready = 1'b1; in_valid = 1'b1; reg_we = 1'b0; flag_we = 1'b1; alu = 8'h00; dst = 3'd6;
    step();
    idle_inputs();
    @(negedge clk);
    total++; if ({zf, pf, of} !== 3'b100) begin bad++; $display("FAIL cmp_flags: got %b want 100", {zf, pf, of}); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL cmp_no_entry: got %b want 0", wb_valid); end
    step();
  endtask

  task automatic test_flush();
    // Two buffered entries, flush with a flag-writing zero result alongside.
    wb_ready = 1'b0; in_valid = 1'b1; reg_we = 1'b1; flag_we = 1'b0; alu = 8'h81; dst = 3'd6;
    q.push_back(wb_t'{3'd6, 8'h81});
    step();
    flag_we = 1'b1; alu = 8'h07; dst = 3'd7;
    q.push_back(wb_t'{3'd7, 8'h07});
    step();
    flush = 1'b1; in_valid = 1'b1; flag_we = 1'b1; reg_we = 1'b1; alu = 8'h00; dst = 3'd1;
    step();
    q.delete();
    idle_inputs();
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", wb_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    total++; if ({zf, pf, of} !== 3'b011) begin bad++; $display("FAIL flush_flags: got %b want 011", {zf, pf, of}); end
    step();
    // One entry, flush while the register file takes it; the input in the flush cycle is ignored.
    in_valid = 1'b1; reg_we = 1'b1; flag_we = 1'b0; alu = 8'h55; dst = 3'd2;
    q.push_back(wb_t'{3'd2, 8'h55});
    step();
    flush = 1'b1; flag_we = 1'b1; alu = 8'h00; dst = 3'd4; wb_ready = 1'b1;
    step();
    idle_inputs();
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_deq_valid: got %b want 0", wb_valid); end
    total++; if (q.size() != 0) begin bad++; $display("FAIL flush_deq_done: %0d pending, want 0", q.size()); q.delete(); end
    total++; if ({zf, pf, of} !== 3'b011) begin bad++; $display("FAIL flush_deq_flags: got %b want 011", {zf, pf, of}); end
    step();
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0; in_valid = 1'b1; reg_we = 1'b1; flag_we = 1'b1; alu = 8'h01; dst = 3'd1;
    step();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", wb_valid); end
    total++; if ({zf, pf, of} !== 3'b000) begin bad++; $display("FAIL rstmid_flags: got %b want 000", {zf, pf, of}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'h00;
    wb_ready = 1'b1; in_valid = 1'b1; reg_we = 1'b1; flag_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      alu = d; dst = 3'(i);
      q.push_back(wb_t'{3'(i), d});
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); end
      step();
    end
    idle_inputs();
    step();
    @(negedge clk);
    total++; if (q.size() != 0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_throughput: pending=%0d valid=%b, want 0/0", q.size(), wb_valid); q.delete();
    end
    total++; if ({zf, pf, of} !== {(d == 8'h00), ^d, d[0]}) begin
      bad++; $display("FAIL b2b_flags: got %b want %b", {zf, pf, of}, {(d == 8'h00), ^d, d[0]});
    end
    step();
  endtask

  task automatic test_forwarding();
    logic       exp_hit1;
    logic [7:0] exp_d1;
    logic [7:0] exp_d2;
`ifdef ALU_WB_FWD_EN
    exp_hit1 = 1'b1; exp_d1 = 8'h11; exp_d2 = 8'h22;
`else
    exp_hit1 = 1'b0; exp_d1 = 8'h00; exp_d2 = 8'h00;
`endif
    wb_ready = 1'b0; in_valid = 1'b1; reg_we = 1'b1; flag_we = 1'b0; alu = 8'h11; dst = 3'd3; query = 3'd3;
    q.push_back(wb_t'{3'd3, 8'h11});
    step();
    alu = 8'h22;
    q.push_back(wb_t'{3'd3, 8'h22});
    @(negedge clk);
    total++; if ({fwd_hit, fwd_data} !== {exp_hit1, exp_d1}) begin
      bad++; $display("FAIL fwd_one: got %b/%h want %b/%h", fwd_hit, fwd_data, exp_hit1, exp_d1);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++; if ({fwd_hit, fwd_data} !== {exp_hit1, exp_d2}) begin
      bad++; $display("FAIL fwd_newest: got %b/%h want %b/%h", fwd_hit, fwd_data, exp_hit1, exp_d2);
    end
    query = 3'd4;
    #1;
    total++; if ({fwd_hit, fwd_data} !== 9'd0) begin
      bad++; $display("FAIL fwd_miss: got %b/%h want 0/00", fwd_hit, fwd_data);
    end
    step();
    wb_ready = 1'b1;
    wait_drain("fwd");
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0; wb_ready = 1'b0; query = 3'd0;
    test_reset();
    test_single();
    test_backpressure();
    test_cmp();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_forwarding();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
